seq_detect_counter: RTL and testbench
=====================================

Name: seq_detect_counter

Overview:
- Downstream consumer of the AND-gated flip-flop stage; samples that stage's registered output (op0) once per clock.
- Keeps a shift history, counts rising edges and detects the serial pattern 1011 (overlap allowed) with a Mealy FSM.
- Exposes counts and a one-cycle match pulse for the bench and later display stages.

Parameters:
- CNT_WIDTH, 8, width of rise_count and match_count.
- HIST_WIDTH, 8, number of past samples held in history.

Ports:
- clk  input  1  system clock, all state updates on rising edge.
- clear0  input  1  asynchronous active-low reset.
- enable  input  1  sample qualifier; 0 freezes all state.
- clr_counts  input  1  synchronous clear of counters and overflow flag.
- ip0  input  1  serial sample; connects to the flip-flop stage's op0.
- history  output  HIST_WIDTH  last samples, newest in bit 0.
- rise_count  output  CNT_WIDTH  number of 0->1 transitions sampled.
- match  output  1  one-cycle pulse on pattern detection.
- match_count  output  CNT_WIDTH  number of detections.
- overflow  output  1  sticky; set when either counter saturates.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low (ports clk and clear0). While clear0=0: history=0, prev sample=0, rise_count=0, match_count=0, match=0, overflow=0, FSM=S0. Release takes effect at the next posedge clk.
- Sample: occurs at a posedge with enable=1. enable=0 holds history, counters, FSM and prev; match forced to 0 that cycle.
- History: history <= {history[HIST_WIDTH-2:0], ip0} on each sample.
- Rise detect: rise when ip0=1 and prev=0; prev <= ip0 on each sample. prev resets to 0, so a first sample of 1 counts as a rise.
- FSM states (2-bit encoding):
  - S0 (none): ip0=1 -> S1, else S0.
  - S1 ("1"): ip0=0 -> S2, else S1.
  - S2 ("10"): ip0=1 -> S3, else S0.
  - S3 ("101"): ip0=1 -> match, go to S1 (overlap); ip0=0 -> S2.
- match: registered output. Asserted for exactly the one cycle following the sampling edge that completed 1011; deasserted otherwise. Back-to-back 1011011 gives two pulses, 3 samples apart.
- Counters: increment by 1 on rise / match-event respectively. They saturate at all-ones and never wrap. An increment attempted at all-ones sets overflow; overflow then holds until clr_counts or reset.
- clr_counts=1 at posedge: rise_count, match_count and overflow all go to 0. clr_counts wins over a same-cycle increment; that event is discarded from the counters. History, prev, FSM and match still update normally if enable=1. clr_counts acts regardless of enable.
- Mid-operation reset: reset mid-pattern discards partial match; the detector restarts in S0 and needs a full 4 new samples.
- Latency: ip0 to history/counters is 1 cycle; ip0 to match is 1 cycle after the 4th pattern bit is sampled.

Decomposition:
- Shared package: FSM state encodings S0..S3 (2'b00..2'b11); PATTERN constant 4'b1011; default CNT_WIDTH/HIST_WIDTH constants.
- One natural sub-module: sat_counter (CNT_WIDTH, inc, clr, count, sat_hit), instantiated twice for rise_count and match_count. The FSM, history and prev logic stay in the top level.

Test Plan:
- Reset: drive clear0=0 mid-run with ip0=1 toggling -> all outputs 0 immediately (async, before the next clock edge); after release, first sample ip0=1 -> rise_count=1, history=8'h01.
- Pattern with overlap: serial ip0 1,0,1,1,0,1,1 with enable=1 -> match pulses after the 4th and 7th samples; match_count=2; rise_count=3; history=8'h5B.
- Near-miss and enable gating: stream 1,0,1,0,1,1 -> one match after the 6th sample (S3->S2 path). Repeat with enable=0 inserted between samples 2 and 3 while ip0=0 -> the freeze changes nothing, same single match.
- Saturation: toggle ip0 0/1 for 260 rising edges -> rise_count stays 8'hFF; overflow=1 from the 256th rise onward; match_count is unaffected.
- Clear priority: assert clr_counts on the same edge that completes 1011 -> match=1 the next cycle but match_count=0 and overflow=0; the following 1011 gives match_count=1.
- Mid-pattern reset: send 1,0,1, pulse clear0 low, then send 1 -> no match; the FSM must see a fresh 1,0,1,1 before match asserts.

Source files
------------

// File: rtl/seq_detect_counter_pkg.sv
// Shared types and constants for the serial 1011 detector and its counters.
package seq_detect_counter_pkg;

    typedef enum logic [1:0] {
        S0 = 2'b00,  // nothing matched
        S1 = 2'b01,  // "1"
        S2 = 2'b10,  // "10"
        S3 = 2'b11   // "101"
    } state_t;

    localparam logic [3:0]  PATTERN            = 4'b1011;
    localparam int unsigned DEFAULT_CNT_WIDTH  = 8;
    localparam int unsigned DEFAULT_HIST_WIDTH = 8;

endpackage

// File: rtl/seq_detect_counter_if.sv
// Sample/control inputs and observation outputs of the detector, bundled as one port.
interface seq_detect_counter_if
    import seq_detect_counter_pkg::*;
#(
    parameter int unsigned CNT_WIDTH  = DEFAULT_CNT_WIDTH,
    parameter int unsigned HIST_WIDTH = DEFAULT_HIST_WIDTH
) ();

    logic                  enable;
    logic                  clr_counts;
    logic                  ip0;
    logic [HIST_WIDTH-1:0] history;
    logic [CNT_WIDTH-1:0]  rise_count;
    logic                  match;
    logic [CNT_WIDTH-1:0]  match_count;
    logic                  overflow;

    modport master (
        output enable, clr_counts, ip0,
        input  history, rise_count, match, match_count, overflow
    );

    modport slave (
        input  enable, clr_counts, ip0,
        output history, rise_count, match, match_count, overflow
    );

endinterface

// File: rtl/seq_detect_counter_sat_counter.sv
// Saturating up-counter; sat_hit flags an increment attempted while already all-ones.
module sat_counter #(
    parameter int unsigned CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 inc,
    input  logic                 clr,
    output logic [CNT_WIDTH-1:0] count,
    output logic                 sat_hit
);

    assign sat_hit = inc && (count == '1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/seq_detect_counter.sv
// Samples ip0 when enabled: keeps a shift history, counts rising edges and
// detects 1011 (overlapping) with a registered Mealy match pulse.
module seq_detect_counter
    import seq_detect_counter_pkg::*;
#(
    parameter int unsigned CNT_WIDTH  = DEFAULT_CNT_WIDTH,
    parameter int unsigned HIST_WIDTH = DEFAULT_HIST_WIDTH
) (
    input  logic                 clk,
    input  logic                 clear0,
    seq_detect_counter_if.slave  bus
);

    state_t                state_q, state_d;
    logic                  match_d, match_q;
    logic [HIST_WIDTH-1:0] hist_q;
    logic                  prev_q;
    logic                  ovf_q;
    logic                  rise_inc;
    logic                  rise_hit, match_hit;
    logic [CNT_WIDTH-1:0]  rise_cnt, match_cnt;

    assign rise_inc = bus.enable && bus.ip0 && !prev_q;

    always_comb begin
        state_d = state_q;
        match_d = 1'b0;
        if (bus.enable) begin
            case (state_q)
                S0: state_d = (bus.ip0 == PATTERN[3]) ? S1 : S0;
                S1: state_d = (bus.ip0 == PATTERN[2]) ? S2 : S1;
                S2: state_d = (bus.ip0 == PATTERN[1]) ? S3 : S0;
                S3: begin
                    // Trailing 1 of a match doubles as the leading 1 of the next.
                    if (bus.ip0 == PATTERN[0]) begin
                        match_d = 1'b1;
                        state_d = S1;
                    end else begin
                        state_d = S2;
                    end
                end
                default: state_d = S0;
            endcase
        end
    end

    always_ff @(posedge clk or negedge clear0) begin
        if (!clear0) begin
            state_q <= S0;
            match_q <= 1'b0;
            hist_q  <= '0;
            prev_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            match_q <= match_d;
            if (bus.enable) begin
                hist_q <= {hist_q[HIST_WIDTH-2:0], bus.ip0};
                prev_q <= bus.ip0;
            end
            if (bus.clr_counts) begin
                ovf_q <= 1'b0;
            end else if (rise_hit || match_hit) begin
                ovf_q <= 1'b1;
            end
        end
    end

    sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_rise_cnt (
        .clk     (clk),
        .rst_n   (clear0),
        .inc     (rise_inc),
        .clr     (bus.clr_counts),
        .count   (rise_cnt),
        .sat_hit (rise_hit)
    );

    sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_match_cnt (
        .clk     (clk),
        .rst_n   (clear0),
        .inc     (match_d),
        .clr     (bus.clr_counts),
        .count   (match_cnt),
        .sat_hit (match_hit)
    );

    assign bus.history     = hist_q;
    assign bus.rise_count  = rise_cnt;
    assign bus.match       = match_q;
    assign bus.match_count = match_cnt;
    assign bus.overflow    = ovf_q;

endmodule

// File: tb/tb_seq_detect_counter.sv
// Directed-vector bench: stimulus pushes expected outputs, a monitor pops and compares.
module tb_seq_detect_counter;

    localparam logic [4:0] M_ALL = 5'b11111;
    localparam logic [4:0] M_CNT = 5'b11010;  // rise_count, match_count, overflow

    typedef struct {
        string      name;
        logic [4:0] mask;
        logic [7:0] hist;
        logic [7:0] rc;
        logic       m;
        logic [7:0] mc;
        logic       ov;
    } exp_t;

    logic clktb = 1'b0;
    logic clear0;
    int   checks = 0;
    int   errors = 0;
    exp_t q[$];
    event mon_ev;

    always #5 clktb = ~clktb;

    seq_detect_counter_if #(.CNT_WIDTH(8), .HIST_WIDTH(8)) bus ();

    seq_detect_counter #(.CNT_WIDTH(8), .HIST_WIDTH(8)) dut (
        .clk    (clktb),
        .clear0 (clear0),
        .bus    (bus)
    );

    task automatic cmp(input string name, input string field,
                       input logic [7:0] act, input logic [7:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s.%s: got %h, expected %h (t=%0t)", name, field, act, req, $time);
        end
    endtask

    initial begin
        exp_t e;
        forever begin
            @(negedge clktb or mon_ev);
            while (q.size() > 0) begin
                e = q.pop_front();
                if (e.mask[0]) cmp(e.name, "history",     bus.history,            e.hist);
                if (e.mask[1]) cmp(e.name, "rise_count",  bus.rise_count,         e.rc);
                if (e.mask[2]) cmp(e.name, "match",       {7'd0, bus.match},      {7'd0, e.m});
                if (e.mask[3]) cmp(e.name, "match_count", bus.match_count,        e.mc);
                if (e.mask[4]) cmp(e.name, "overflow",    {7'd0, bus.overflow},   {7'd0, e.ov});
            end
        end
    end

    task automatic push_exp(input string name, input logic [4:0] mask, input logic [7:0] h,
                            input logic [7:0] rc, input logic m, input logic [7:0] mc,
                            input logic ov);
        exp_t e;
        e.name = name; e.mask = mask; e.hist = h; e.rc = rc; e.m = m; e.mc = mc; e.ov = ov;
        q.push_back(e);
    endtask

    // Apply one set of inputs across a rising edge; returns 1 time unit after it.
    task automatic step(input logic ip, input logic en, input logic clr);
        bus.ip0 = ip;
        bus.enable = en;
        bus.clr_counts = clr;
        @(posedge clktb);
        #1;
    endtask

    task automatic sc(input string name, input logic ip, input logic en, input logic clr,
                      input logic [7:0] h, input logic [7:0] rc, input logic m,
                      input logic [7:0] mc, input logic ov);
        step(ip, en, clr);
        push_exp(name, M_ALL, h, rc, m, mc, ov);
    endtask

    task automatic do_reset();
        @(negedge clktb);
        #1;
        clear0 = 1'b0;
        #2;
        clear0 = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, expected finish before t=200000");
        $fatal(1);
    end

    initial begin
        clear0 = 1'b0;
        bus.ip0 = 1'b0;
        bus.enable = 1'b0;
        bus.clr_counts = 1'b0;
        repeat (2) @(posedge clktb);
        #1;
        push_exp("reset", M_ALL, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
        clear0 = 1'b1;

        // Async reset mid-run, then first sample after release counts as a rise
        sc("a1", 1'b1, 1'b1, 1'b0, 8'h01, 8'd1, 1'b0, 8'd0, 1'b0);
        sc("a2", 1'b0, 1'b1, 1'b0, 8'h02, 8'd1, 1'b0, 8'd0, 1'b0);
        sc("a3", 1'b1, 1'b1, 1'b0, 8'h05, 8'd2, 1'b0, 8'd0, 1'b0);
        @(negedge clktb);
        #1;
        clear0 = 1'b0;
        #1;
        push_exp("async_rst", M_ALL, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
        -> mon_ev;
        sc("in_rst0", 1'b0, 1'b1, 1'b0, 8'h00, 8'd0, 1'b0, 8'd0, 1'b0);
        sc("in_rst1", 1'b1, 1'b1, 1'b0, 8'h00, 8'd0, 1'b0, 8'd0, 1'b0);
        clear0 = 1'b1;
        sc("post_rst", 1'b1, 1'b1, 1'b0, 8'h01, 8'd1, 1'b0, 8'd0, 1'b0);

        // Overlapping 1011011
        do_reset();
        sc("ov1", 1'b1, 1'b1, 1'b0, 8'h01, 8'd1, 1'b0, 8'd0, 1'b0);
        sc("ov2", 1'b0, 1'b1, 1'b0, 8'h02, 8'd1, 1'b0, 8'd0, 1'b0);
        sc("ov3", 1'b1, 1'b1, 1'b0, 8'h05, 8'd2, 1'b0, 8'd0, 1'b0);
        sc("ov4", 1'b1, 1'b1, 1'b0, 8'h0B, 8'd2, 1'b1, 8'd1, 1'b0);
        sc("ov5", 1'b0, 1'b1, 1'b0, 8'h16, 8'd2, 1'b0, 8'd1, 1'b0);
        sc("ov6", 1'b1, 1'b1, 1'b0, 8'h2D, 8'd3, 1'b0, 8'd1, 1'b0);
        sc("ov7", 1'b1, 1'b1, 1'b0, 8'h5B, 8'd3, 1'b1, 8'd2, 1'b0);
        sc("ov8", 1'b0, 1'b1, 1'b0, 8'hB6, 8'd3, 1'b0, 8'd2, 1'b0);

        // Near miss 101011 via S3->S2
        do_reset();
        sc("nm1", 1'b1, 1'b1, 1'b0, 8'h01, 8'd1, 1'b0, 8'd0, 1'b0);
        sc("nm2", 1'b0, 1'b1, 1'b0, 8'h02, 8'd1, 1'b0, 8'd0, 1'b0);
        sc("nm3", 1'b1, 1'b1, 1'b0, 8'h05, 8'd2, 1'b0, 8'd0, 1'b0);
        sc("nm4", 1'b0, 1'b1, 1'b0, 8'h0A, 8'd2, 1'b0, 8'd0, 1'b0);
        sc("nm5", 1'b1, 1'b1, 1'b0, 8'h15, 8'd3, 1'b0, 8'd0, 1'b0);
        sc("nm6", 1'b1, 1'b1, 1'b0, 8'h2B, 8'd3, 1'b1, 8'd1, 1'b0);

        // Same stream with a frozen cycle, then freeze right after a match
        do_reset();
        sc("fz1", 1'b1, 1'b1, 1'b0, 8'h01, 8'd1, 1'b0, 8'd0, 1'b0);
        sc("fz2", 1'b0, 1'b1, 1'b0, 8'h02, 8'd1, 1'b0, 8'd0, 1'b0);
        sc("fz_hold", 1'b0, 1'b0, 1'b0, 8'h02, 8'd1, 1'b0, 8'd0, 1'b0);
        sc("fz3", 1'b1, 1'b1, 1'b0, 8'h05, 8'd2, 1'b0, 8'd0, 1'b0);
        sc("fz4", 1'b0, 1'b1, 1'b0, 8'h0A, 8'd2, 1'b0, 8'd0, 1'b0);
        sc("fz5", 1'b1, 1'b1, 1'b0, 8'h15, 8'd3, 1'b0, 8'd0, 1'b0);
        sc("fz6", 1'b1, 1'b1, 1'b0, 8'h2B, 8'd3, 1'b1, 8'd1, 1'b0);
        sc("fz_m0", 1'b1, 1'b0, 1'b0, 8'h2B, 8'd3, 1'b0, 8'd1, 1'b0);
        sc("fz7", 1'b1, 1'b1, 1'b0, 8'h57, 8'd3, 1'b0, 8'd1, 1'b0);

        // Rise counter saturation
        do_reset();
        for (int i = 1; i <= 260; i++) begin
            step(1'b0, 1'b1, 1'b0);
            step(1'b1, 1'b1, 1'b0);
            push_exp($sformatf("sat%0d", i), M_CNT, 8'h00,
                     (i > 255) ? 8'hFF : 8'(i), 1'b0, 8'd0, (i >= 256));
        end
        step(1'b0, 1'b1, 1'b1);
        push_exp("sat_clr", M_CNT, 8'h00, 8'd0, 1'b0, 8'd0, 1'b0);

        // clr_counts on the completing edge discards that match from the counter
        do_reset();
        sc("cp1", 1'b1, 1'b1, 1'b0, 8'h01, 8'd1, 1'b0, 8'd0, 1'b0);
        sc("cp2", 1'b0, 1'b1, 1'b0, 8'h02, 8'd1, 1'b0, 8'd0, 1'b0);
        sc("cp3", 1'b1, 1'b1, 1'b0, 8'h05, 8'd2, 1'b0, 8'd0, 1'b0);
        sc("cp4", 1'b1, 1'b1, 1'b1, 8'h0B, 8'd0, 1'b1, 8'd0, 1'b0);
        sc("cp5", 1'b1, 1'b1, 1'b0, 8'h17, 8'd0, 1'b0, 8'd0, 1'b0);
        sc("cp6", 1'b0, 1'b1, 1'b0, 8'h2E, 8'd0, 1'b0, 8'd0, 1'b0);
        sc("cp7", 1'b1, 1'b1, 1'b0, 8'h5D, 8'd1, 1'b0, 8'd0, 1'b0);
        sc("cp8", 1'b1, 1'b1, 1'b0, 8'hBB, 8'd1, 1'b1, 8'd1, 1'b0);

        // Reset mid-pattern: 101 | reset | 1011
        do_reset();
        sc("mr1", 1'b1, 1'b1, 1'b0, 8'h01, 8'd1, 1'b0, 8'd0, 1'b0);
        sc("mr2", 1'b0, 1'b1, 1'b0, 8'h02, 8'd1, 1'b0, 8'd0, 1'b0);
        sc("mr3", 1'b1, 1'b1, 1'b0, 8'h05, 8'd2, 1'b0, 8'd0, 1'b0);
        do_reset();
        sc("mr4", 1'b1, 1'b1, 1'b0, 8'h01, 8'd1, 1'b0, 8'd0, 1'b0);
        sc("mr5", 1'b0, 1'b1, 1'b0, 8'h02, 8'd1, 1'b0, 8'd0, 1'b0);
        sc("mr6", 1'b1, 1'b1, 1'b0, 8'h05, 8'd2, 1'b0, 8'd0, 1'b0);
        sc("mr7", 1'b1, 1'b1, 1'b0, 8'h0B, 8'd2, 1'b1, 8'd1, 1'b0);

        repeat (2) @(negedge clktb);
        #1;
        if (q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
